// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result unit and its divide datapath.
package hilo_pkg;

   localparam int DIV_ITERS = 32;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'b000,
      CMD_LDMUL = 3'b001,
      CMD_MTHI  = 3'b010,
      CMD_MTLO  = 3'b011,
      CMD_DIVU  = 3'b100,
      CMD_DIV   = 3'b101,
      CMD_RSV0  = 3'b110,
      CMD_RSV1  = 3'b111
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Two's-complement magnitude; 32'h8000_0000 maps to itself, read as unsigned.
   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/hilo_unit_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module div_core
   import hilo_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);

   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dvs_reg;
   logic [4:0]  cnt_reg;
   logic [32:0] shifted;
   logic [32:0] diff;

   // Quotient register starts as the dividend and shifts quotient bits in from the right.
   assign shifted = {rem_reg, quo_reg[31]};
   assign diff    = shifted - {1'b0, dvs_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_reg <= '0;
         quo_reg <= '0;
         dvs_reg <= '0;
         cnt_reg <= '0;
      end else if (load) begin
         rem_reg <= '0;
         quo_reg <= dividend;
         dvs_reg <= divisor;
         cnt_reg <= 5'(DIV_ITERS - 1);
      end else if (step) begin
         if (!diff[32]) begin
            rem_reg <= diff[31:0];
            quo_reg <= {quo_reg[30:0], 1'b1};
         end else begin
            rem_reg <= shifted[31:0];
            quo_reg <= {quo_reg[30:0], 1'b0};
         end
         cnt_reg <= cnt_reg - 5'd1;
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;
   assign last      = (cnt_reg == 5'd0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: multiply capture, MTHI/MTLO, and iterative signed/unsigned divide.
module hilo_unit
   import hilo_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  cmd,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] alu_hi,
   input  logic [31:0] alu_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   state_t      state_reg, state_next;
   cmd_t        cmd_c;
   logic        accept, is_div, is_signed;
   logic        load, step, last;
   logic [31:0] dvd_in, dvs_in, quotient, remainder, q_fix, r_fix;
   logic [31:0] hi_reg, lo_reg, a_reg;
   logic        done_reg, dbz_reg, zero_reg, neg_q_reg, neg_r_reg;

   assign cmd_c     = cmd_t'(cmd);
   assign is_signed = (cmd_c == CMD_DIV);
   assign is_div    = (cmd_c == CMD_DIVU) || is_signed;
   assign accept    = start && (state_reg == IDLE);
   assign dvd_in    = is_signed ? mag(a) : a;
   assign dvs_in    = is_signed ? mag(b) : b;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept && is_div) state_next = (b == 32'd0) ? FIX : DIV;
         DIV:     if (last) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load = accept && is_div;
      step = (state_reg == DIV);
      busy = (state_reg != IDLE);
   end

   div_core u_div_core (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .dividend  (dvd_in),
      .divisor   (dvs_in),
      .quotient  (quotient),
      .remainder (remainder),
      .last      (last)
   );

   assign q_fix = neg_q_reg ? -quotient  : quotient;
   assign r_fix = neg_r_reg ? -remainder : remainder;

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg    <= '0;
         lo_reg    <= '0;
         a_reg     <= '0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
         zero_reg  <= 1'b0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (accept) begin
            dbz_reg <= 1'b0;
            unique case (cmd_c)
               CMD_LDMUL: begin
                  hi_reg <= alu_hi;
                  lo_reg <= alu_lo;
               end
               CMD_MTHI: hi_reg <= a;
               CMD_MTLO: lo_reg <= a;
               CMD_DIVU, CMD_DIV: begin
                  a_reg     <= a;
                  zero_reg  <= (b == 32'd0);
                  neg_q_reg <= is_signed && (a[31] ^ b[31]);
                  neg_r_reg <= is_signed && a[31];
               end
               default: ;
            endcase
            if (!is_div) done_reg <= 1'b1;
         end
         // Divide write-back; HI/LO are untouched until this edge.
         if (state_reg == FIX) begin
            done_reg <= 1'b1;
            if (zero_reg) begin
               lo_reg  <= 32'hFFFF_FFFF;
               hi_reg  <= a_reg;
               dbz_reg <= 1'b1;
            end else begin
               lo_reg <= q_fix;
               hi_reg <= r_fix;
            end
         end
      end
   end

   assign hi          = hi_reg;
   assign lo          = lo_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;

endmodule
